// File: rtl/mover_pkg.sv
// Shared types for the maze sprite movers: headings, movement states and keycode decode.
package mover_pkg;

  // Encoding lets blocked[dir] index the wall flags directly.
  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    LEFT  = 2'd1,
    DOWN  = 2'd2,
    UP    = 2'd3
  } dir_t;

  typedef enum logic {
    IDLE = 1'b0,
    MOVE = 1'b1
  } mv_state_t;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } req_t;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_UP    = 8'h1A;

  function automatic req_t key_decode(input logic [7:0] key);
    req_t r;
    r.valid = 1'b1;
    r.dir   = LEFT;
    case (key)
      KEY_LEFT:  r.dir = LEFT;
      KEY_RIGHT: r.dir = RIGHT;
      KEY_DOWN:  r.dir = DOWN;
      KEY_UP:    r.dir = UP;
      default:   r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/turn_buffer.sv
// Holds the most recent direction key for TURN_HOLD frames so a turn can be taken
// as soon as the corridor opens; presents this frame's key in preference to the stored one.
module turn_buffer
  import mover_pkg::*;
#(
  parameter int TURN_HOLD = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] keycode_i,
  input  logic       take_i,
  output req_t       eff_o,
  output logic       pending_o
);

  localparam int HW = $clog2(TURN_HOLD + 1);

  logic          req_valid_q, req_valid_d;
  dir_t          req_dir_q, req_dir_d;
  logic [HW-1:0] hold_q, hold_d;
  req_t          key;

  always_comb begin
    key         = key_decode(keycode_i);
    req_valid_d = req_valid_q;
    req_dir_d   = req_dir_q;
    hold_d      = hold_q;

    if (key.valid) begin
      eff_o = key;
    end else begin
      eff_o.valid = req_valid_q;
      eff_o.dir   = req_dir_q;
    end

    if (take_i) begin
      req_valid_d = 1'b0;
      hold_d      = '0;
    end else if (key.valid) begin
      req_valid_d = 1'b1;
      req_dir_d   = key.dir;
      hold_d      = HW'(TURN_HOLD);
    end else if (req_valid_q) begin
      hold_d = hold_q - HW'(1);
      if (hold_q == HW'(1)) req_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_valid_q <= 1'b0;
      req_dir_q   <= LEFT;
      hold_q      <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_dir_q   <= req_dir_d;
      hold_q      <= hold_d;
    end
  end

  assign pending_o = req_valid_q;

endmodule

// File: rtl/sprite_mover.sv
// Frame-rate maze sprite mover: speed divider, IDLE/MOVE heading FSM and tunnel wrap on X.
module sprite_mover
  import mover_pkg::*;
#(
  parameter int X_START    = 320,
  parameter int Y_START    = 274,
  parameter int SIZE       = 8,
  parameter int STEP       = 1,
  parameter int SPEED_DIV  = 1,
  parameter int TURN_HOLD  = 16,
  parameter int X_WRAP_MIN = 120,
  parameter int X_WRAP_MAX = 520
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [3:0] blocked,
  output logic [9:0] PosX,
  output logic [9:0] PosY,
  output logic [9:0] Size,
  output dir_t       Dir,
  output logic       Moving,
  output logic       TurnPending
);

  localparam int         DW     = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam logic [9:0] STEP10 = 10'(STEP);
  localparam logic [9:0] XMIN   = 10'(X_WRAP_MIN);
  localparam logic [9:0] XMAX   = 10'(X_WRAP_MAX);

  mv_state_t     state_q, state_d;
  dir_t          dir_q, dir_d, mv_dir;
  logic [9:0]    x_q, x_d, y_q, y_d, nx;
  logic [DW-1:0] div_q, div_d;
  logic          step, take, do_move;
  req_t          eff;

  turn_buffer #(.TURN_HOLD(TURN_HOLD)) u_turn (
    .clk_i     (frame_clk),
    .rst_i     (Reset),
    .keycode_i (keycode),
    .take_i    (take),
    .eff_o     (eff),
    .pending_o (TurnPending)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    nx      = x_q;
    take    = 1'b0;
    do_move = 1'b0;
    mv_dir  = dir_q;
    step    = (div_q == DW'(SPEED_DIV - 1));
    div_d   = step ? '0 : div_q + DW'(1);

    if (step) begin
      if (eff.valid && !blocked[eff.dir]) begin
        state_d = MOVE;
        dir_d   = eff.dir;
        mv_dir  = eff.dir;
        do_move = 1'b1;
        take    = 1'b1;
      end else if (state_q == MOVE && !blocked[dir_q]) begin
        do_move = 1'b1;
      end else if (state_q == MOVE) begin
        // Stopping at a wall keeps any buffered request alive.
        state_d = IDLE;
      end
    end

    if (do_move) begin
      case (mv_dir)
        RIGHT: nx  = x_q + STEP10;
        LEFT:  nx  = x_q - STEP10;
        DOWN:  y_d = y_q + STEP10;
        UP:    y_d = y_q - STEP10;
        default: ;
      endcase
      if (mv_dir == RIGHT || mv_dir == LEFT) begin
        if (nx < XMIN)      x_d = XMAX;
        else if (nx > XMAX) x_d = XMIN;
        else                x_d = nx;
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      dir_q   <= LEFT;
      x_q     <= 10'(X_START);
      y_q     <= 10'(Y_START);
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      div_q   <= div_d;
    end
  end

  assign PosX   = x_q;
  assign PosY   = y_q;
  assign Size   = 10'(SIZE);
  assign Dir    = dir_q;
  assign Moving = (state_q == MOVE);

endmodule
